multicycle_main_fsm: RTL
========================

Name: multicycle_main_fsm

Overview:
- Main control state machine for the multicycle variant of the RISC-V core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and write enables, and supplies ALUOp to the downstream ALU decoder.
- The ALU decoder takes op5, funct3 and funct7 directly from the instruction register; this block only provides ALUOp.
- Adds a memory-ready stall so fetch and data accesses can take several cycles.

Parameters:
- NONE_ILLEGAL_TRAP, 0, when 1 an unsupported opcode parks the FSM in ILLEGAL until reset; when 0 it returns to FETCH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- op  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]; used for branch sense
- zero  input  1  ALU zero flag (combinational, same cycle)
- mem_ready  input  1  unified memory completes access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address: 0=PC, 1=Result
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction and OldPC register enable
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  output  2  00=WriteData, 01=ImmExt, 10=constant 4
- ALUOp  output  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded
- RegWrite  output  1  register file write enable
- illegal  output  1  unsupported opcode detected
- state  output  4  current state encoding, for debug and verification

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10, ILLEGAL=11. Unused codes go to FETCH next cycle.
- Reset: async assertion forces state=FETCH immediately, regardless of any in-flight access. All outputs follow the FETCH decode given mem_ready.
- Outputs are Moore decodes of state, except the mem_ready-qualified and zero-qualified terms noted below. Any output not listed for a state is 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=mem_ready and PCWrite=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - anything else -> illegal=1 this cycle, then ILLEGAL if NONE_ILLEGAL_TRAP=1, else FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in this state. Hold until mem_ready=1, then go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - Taken when (funct3=000 and zero=1) or (funct3=001 and zero=0); PCWrite = taken.
  - Other funct3 values are never taken.
  - Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Go to ALUWB.
- ILLEGAL: all enables 0, illegal=1 held. Exit only by reset.
- Latency with mem_ready tied high:
  - lw 5 cycles; sw 4; R-type and I-type 4; branch 3; jal 4.
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Invariants:
  - PCWrite is never asserted while MemWrite=1.
  - IRWrite is asserted only in FETCH.
  - RegWrite is asserted only in MEMWB and ALUWB.

Test Plan:
- Reset release with mem_ready=1 and op=0110011 -> state sequence 0,1,6,8,0; ALUOp=10 in state 6; RegWrite=1 only in state 8.
- lw (op=0000011) with mem_ready low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; AdrSrc=1 throughout MEMREAD; RegWrite with ResultSrc=01 in state 4.
- sw (op=0100011) with mem_ready low 1 cycle in FETCH -> FETCH held 2 cycles; IRWrite and PCWrite high only in the second; MemWrite=1 in state 5 and never elsewhere.
- Branches, each checked in BRANCH (ALUOp=01):
  - beq (funct3=000) with zero=1 -> PCWrite=1.
  - bne (funct3=001) with zero=1 -> PCWrite=0.
  - funct3=100 with zero=1 -> PCWrite=0.
- jal (op=1101111) -> states 0,1,10,8,0; PCWrite=1 in state 10 with ALUSrcA=01 and ALUSrcB=10.
- Illegal op 1111111 with NONE_ILLEGAL_TRAP=1 -> illegal pulses in DECODE, FSM parks in state 11. Async rst asserted mid-MEMWRITE -> state=0 immediately and MemWrite drops the same cycle.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RISC-V core, with memory-ready stalls.
module multicycle_main_fsm #(
  parameter bit NONE_ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  state_t cur_state;
  state_t next_state;
  logic   taken;

  assign state = cur_state;
  assign taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= FETCH;
    else     cur_state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = '0;
    ALUSrcA    = '0;
    ALUSrcB    = '0;
    ALUOp      = '0;
    RegWrite   = 1'b0;
    illegal    = 1'b0;
    case (cur_state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011,
          7'b0100011: next_state = MEMADR;
          7'b0110011: next_state = EXECUTER;
          7'b0010011: next_state = EXECUTEI;
          7'b1100011: next_state = BRANCH;
          7'b1101111: next_state = JAL;
          default: begin
            illegal    = 1'b1;
            next_state = NONE_ILLEGAL_TRAP ? ILLEGAL : FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        next_state = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        PCWrite    = taken;
        next_state = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        next_state = ALUWB;
      end
      ILLEGAL: begin
        illegal    = 1'b1;
        next_state = ILLEGAL;
      end
      default: next_state = FETCH;
    endcase
  end

endmodule
